// File: rtl/pdp8_pkg.sv
// ============================================================================
// pdp8_pkg
// ----------------------------------------------------------------------------
// Purpose : Shared definitions for the PDP-8 fetch/decode stage. This package
//           holds the machine widths, the octal opcode constants, the
//           instruction field positions, the two decoded-instruction structs
//           handed to the execution unit, and the decode FSM state type.
// Ports   : none (package)
// Config  : IFD_ILLEGAL_HALT_EN is consumed by pdp8_decode, not here.
// ============================================================================
package pdp8_pkg;

   localparam int ADDR_WIDTH = 12;
   localparam int DATA_WIDTH = 12;

   // Major opcodes live in instr[11:9]; values are the classic octal codes.
   localparam logic [2:0] OP_AND = 3'o0;
   localparam logic [2:0] OP_TAD = 3'o1;
   localparam logic [2:0] OP_ISZ = 3'o2;
   localparam logic [2:0] OP_DCA = 3'o3;
   localparam logic [2:0] OP_JMS = 3'o4;
   localparam logic [2:0] OP_JMP = 3'o5;
   localparam logic [2:0] OP_IOT = 3'o6;
   localparam logic [2:0] OP_OPR = 3'o7;

   // Instruction field positions.
   localparam int OPCODE_MSB   = 11;
   localparam int OPCODE_LSB   = 9;
   localparam int INDIRECT_BIT = 8;
   localparam int PAGE_BIT     = 7;
   localparam int OFFSET_WIDTH = 7;
   localparam int PAGE_WIDTH   = ADDR_WIDTH - OFFSET_WIDTH;

   // Memory-reference decode; 'and' is a reserved word, hence the trailing underscore.
   typedef struct packed {
      logic and_;
      logic tad;
      logic isz;
      logic dca;
      logic jms;
      logic jmp;
      logic indirect;
      logic nop;
   } pdp_mem_opcode_s;

   // Operate-group decode; cla is shared by group 1 and group 2.
   typedef struct packed {
      logic cla;
      logic cll;
      logic cma;
      logic cml;
      logic rar;
      logic ral;
      logic rtr;
      logic rtl;
      logic iac;
      logic sma;
      logic sza;
      logic snl;
      logic spa;
      logic sna;
      logic szl;
      logic skp;
      logic osr;
      logic hlt;
   } pdp_op7_opcode_s;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LOAD   = 3'd2,
      ISSUE  = 3'd3,
      RETIRE = 3'd4
   } ifd_state_e;

endpackage

// File: rtl/pdp8_decode.sv
// ============================================================================
// pdp8_decode
// ----------------------------------------------------------------------------
// Purpose : Purely combinational PDP-8 instruction decoder. Turns a 12-bit
//           instruction word plus the page bits of the fetching PC into the
//           memory-reference struct, the operate-group struct and the
//           page-resolved operand address.
// Ports   : instr_i      - instruction word
//           pc_page_i    - PC[11:7] of the PC the word was fetched from
//           mem_op_o     - memory-reference decode (incl. indirect, nop)
//           op7_op_o     - operate-group decode
//           base_addr_o  - effective operand address (0 for non memory-ref)
// Config  : IFD_ILLEGAL_HALT_EN - when defined, unsupported words (IOT,
//           group 3, group-1 rar+ral) decode to hlt instead of nop.
// ============================================================================
module pdp8_decode
   import pdp8_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] instr_i,
   input  logic [PAGE_WIDTH-1:0] pc_page_i,
   output pdp_mem_opcode_s       mem_op_o,
   output pdp_op7_opcode_s       op7_op_o,
   output logic [ADDR_WIDTH-1:0] base_addr_o
);

   logic [2:0] opcode;
   logic       memRef;
   logic       unsupported;

   assign opcode = instr_i[OPCODE_MSB:OPCODE_LSB];

   // Decode the word field by field. A word that decodes to nothing at all
   // (e.g. a bare group-1 or group-2 NOP) is reported as nop so the exec unit
   // always sees exactly one non-zero encoding while the instruction is issued.
   always_comb begin
      mem_op_o    = '0;
      op7_op_o    = '0;
      base_addr_o = '0;
      memRef      = 1'b0;
      unsupported = 1'b0;

      case (opcode)
         OP_AND: begin mem_op_o.and_ = 1'b1; memRef = 1'b1; end
         OP_TAD: begin mem_op_o.tad  = 1'b1; memRef = 1'b1; end
         OP_ISZ: begin mem_op_o.isz  = 1'b1; memRef = 1'b1; end
         OP_DCA: begin mem_op_o.dca  = 1'b1; memRef = 1'b1; end
         OP_JMS: begin mem_op_o.jms  = 1'b1; memRef = 1'b1; end
         OP_JMP: begin mem_op_o.jmp  = 1'b1; memRef = 1'b1; end
         OP_OPR: begin
            if (!instr_i[INDIRECT_BIT]) begin
               // Group 1: rotating both ways at once has no meaning.
               if (instr_i[3] && instr_i[2]) begin
                  unsupported = 1'b1;
               end else begin
                  op7_op_o.cla = instr_i[7];
                  op7_op_o.cll = instr_i[6];
                  op7_op_o.cma = instr_i[5];
                  op7_op_o.cml = instr_i[4];
                  op7_op_o.iac = instr_i[0];
                  op7_op_o.rar = instr_i[3] && !instr_i[1];
                  op7_op_o.rtr = instr_i[3] &&  instr_i[1];
                  op7_op_o.ral = instr_i[2] && !instr_i[1];
                  op7_op_o.rtl = instr_i[2] &&  instr_i[1];
               end
            end else if (instr_i[0]) begin
               // Group 3 (EAE) words are treated as unsupported words.
               unsupported = 1'b1;
            end else begin
               // Group 2: bit 3 flips the sense of the skip conditions.
               op7_op_o.cla = instr_i[7];
               op7_op_o.osr = instr_i[2];
               op7_op_o.hlt = instr_i[1];
               if (!instr_i[3]) begin
                  op7_op_o.sma = instr_i[6];
                  op7_op_o.sza = instr_i[5];
                  op7_op_o.snl = instr_i[4];
               end else begin
                  op7_op_o.spa = instr_i[6];
                  op7_op_o.sna = instr_i[5];
                  op7_op_o.szl = instr_i[4];
                  op7_op_o.skp = (instr_i[6:4] == 3'b000);
               end
            end
         end
         default: unsupported = 1'b1;
      endcase

      if (memRef) begin
         mem_op_o.indirect = instr_i[INDIRECT_BIT];
         base_addr_o = instr_i[PAGE_BIT] ? {pc_page_i, instr_i[OFFSET_WIDTH-1:0]}
                                         : {{PAGE_WIDTH{1'b0}}, instr_i[OFFSET_WIDTH-1:0]};
      end

      if (unsupported) begin
`ifdef IFD_ILLEGAL_HALT_EN
         op7_op_o.hlt = 1'b1;
`else
         mem_op_o.nop = 1'b1;
`endif
      end else if ((mem_op_o == '0) && (op7_op_o == '0)) begin
         mem_op_o.nop = 1'b1;
      end
   end

endmodule

// File: rtl/instr_decode.sv
// ============================================================================
// instr_decode
// ----------------------------------------------------------------------------
// Purpose : PDP-8 fetch/decode stage sitting in front of instr_exec. Fetches
//           the word at PC_value over a dedicated read port, decodes it with
//           pdp8_decode and holds the registered decode until exec takes it
//           via the stall handshake (IDLE, FETCH, LOAD, ISSUE, RETIRE).
// Ports   : clk, reset       - clock, asynchronous active-high reset
//           stall            - exec busy (1) / ready for next instruction (0)
//           PC_value         - address of the next instruction
//           ifu_rd_req       - one-cycle read request
//           ifu_rd_addr      - read address (PC latched at fetch)
//           ifu_rd_data      - read data, valid the cycle after the request
//           base_addr        - page-resolved operand address
//           pdp_mem_opcode   - memory-reference decode
//           pdp_op7_opcode   - operate-group decode
// Config  : IFD_ILLEGAL_HALT_EN (see pdp8_decode).
// ============================================================================
module instr_decode
   import pdp8_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic [ADDR_WIDTH-1:0] PC_value,
   output logic                  ifu_rd_req,
   output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
   input  logic [DATA_WIDTH-1:0] ifu_rd_data,
   output logic [ADDR_WIDTH-1:0] base_addr,
   output pdp_mem_opcode_s       pdp_mem_opcode,
   output pdp_op7_opcode_s       pdp_op7_opcode
);

   ifd_state_e            state_q, state_d;
   logic                  ifu_rd_req_q;
   logic [ADDR_WIDTH-1:0] ifu_rd_addr_q;
   logic [DATA_WIDTH-1:0] ir_q;
   logic [ADDR_WIDTH-1:0] base_addr_q;
   pdp_mem_opcode_s       mem_op_q;
   pdp_op7_opcode_s       op7_op_q;

   logic [DATA_WIDTH-1:0] decWord;
   pdp_mem_opcode_s       decMem;
   pdp_op7_opcode_s       decOp7;
   logic [ADDR_WIDTH-1:0] decBase;

   // In LOAD the word comes straight off the read port; while issued it is
   // re-decoded from the instruction register, which yields the same result
   // because the latched fetch address does not move until the next FETCH.
   assign decWord = (state_q == LOAD) ? ifu_rd_data : ir_q;

   pdp8_decode u_decode (
      .instr_i     (decWord),
      .pc_page_i   (ifu_rd_addr_q[ADDR_WIDTH-1:OFFSET_WIDTH]),
      .mem_op_o    (decMem),
      .op7_op_o    (decOp7),
      .base_addr_o (decBase)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. stall only matters in IDLE, ISSUE and RETIRE; FETCH and
   // LOAD always advance so a read in flight is never abandoned half way.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!stall) state_d = FETCH;
         FETCH:   state_d = LOAD;
         LOAD:    state_d = ISSUE;
         ISSUE:   if (stall) state_d = RETIRE;
         RETIRE:  if (!stall) state_d = FETCH;
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers. The read request is raised on entry to FETCH so the
   // port sees a registered pulse that is high exactly during FETCH, and the
   // PC sampled on that edge becomes the fetch address and page source.
   // Decode outputs are loaded on every edge that lands in ISSUE and cleared
   // on every other edge, so they are zero outside ISSUE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ifu_rd_req_q  <= 1'b0;
         ifu_rd_addr_q <= '0;
         ir_q          <= '0;
         base_addr_q   <= '0;
         mem_op_q      <= '0;
         op7_op_q      <= '0;
      end else begin
         ifu_rd_req_q <= (state_d == FETCH);
         if (state_d == FETCH) begin
            ifu_rd_addr_q <= PC_value;
         end
         if (state_q == LOAD) begin
            ir_q <= ifu_rd_data;
         end
         if (state_d == ISSUE) begin
            base_addr_q <= decBase;
            mem_op_q    <= decMem;
            op7_op_q    <= decOp7;
         end else begin
            base_addr_q <= '0;
            mem_op_q    <= '0;
            op7_op_q    <= '0;
         end
      end
   end

   assign ifu_rd_req     = ifu_rd_req_q;
   assign ifu_rd_addr    = ifu_rd_addr_q;
   assign base_addr      = base_addr_q;
   assign pdp_mem_opcode = mem_op_q;
   assign pdp_op7_opcode = op7_op_q;

endmodule

// File: tb/tb_instr_decode.sv
// ============================================================================
// tb_instr_decode
// ----------------------------------------------------------------------------
// Purpose : Self-checking bench for instr_decode. A driver issues
//           instructions through a small memory responder; expected decodes
//           from a reference model go into a scoreboard queue that a
//           separate monitor pops whenever the DUT presents an instruction.
// Config  : honours IFD_ILLEGAL_HALT_EN in the reference model.
// ============================================================================
module tb_instr_decode;
   import pdp8_pkg::*;

   typedef struct packed {
      pdp_mem_opcode_s       mem;
      pdp_op7_opcode_s       op7;
      logic [ADDR_WIDTH-1:0] ba;
   } exp_t;

   logic                  clk;
   logic                  reset;
   logic                  stall;
   logic [ADDR_WIDTH-1:0] PC_value;
   logic                  ifu_rd_req;
   logic [ADDR_WIDTH-1:0] ifu_rd_addr;
   logic [DATA_WIDTH-1:0] ifu_rd_data;
   logic [ADDR_WIDTH-1:0] base_addr;
   pdp_mem_opcode_s       pdp_mem_opcode;
   pdp_op7_opcode_s       pdp_op7_opcode;

   logic [DATA_WIDTH-1:0] mem [4096];
   exp_t                  sbQ[$];
   exp_t                  held;
   int                    checksTotal;
   int                    checksPassed;
   logic                  prevValid;
   logic                  prevReq;
   logic                  pending;
   logic [ADDR_WIDTH-1:0] pendAddr;

   instr_decode dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .PC_value       (PC_value),
      .ifu_rd_req     (ifu_rd_req),
      .ifu_rd_addr    (ifu_rd_addr),
      .ifu_rd_data    (ifu_rd_data),
      .base_addr      (base_addr),
      .pdp_mem_opcode (pdp_mem_opcode),
      .pdp_op7_opcode (pdp_op7_opcode)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Comparison helper: counts every comparison and reports mismatches.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
      checksTotal++;
      if (act === expv) checksPassed++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
   endtask

   function automatic bit bitOf(input int w, input int n);
      return ((w >> n) & 1) == 1;
   endfunction

   // Reference model written directly from the PDP-8 field rules using
   // octal arithmetic on the word rather than bit slicing.
   function automatic exp_t refModel(input int w, input int pc);
      exp_t e;
      int   op;
      int   skipSel;
      bit   unsup;
      e     = '0;
      unsup = 0;
      op    = w / 512;
      if (op <= 5) begin
         e.mem.indirect = bitOf(w, 8);
         if (bitOf(w, 7)) e.ba = 12'((pc / 128) * 128 + (w % 128));
         else             e.ba = 12'(w % 128);
         case (op)
            0: e.mem.and_ = 1'b1;
            1: e.mem.tad  = 1'b1;
            2: e.mem.isz  = 1'b1;
            3: e.mem.dca  = 1'b1;
            4: e.mem.jms  = 1'b1;
            default: e.mem.jmp = 1'b1;
         endcase
      end else if (op == 6) begin
         unsup = 1;
      end else if (!bitOf(w, 8)) begin
         if (bitOf(w, 3) && bitOf(w, 2)) unsup = 1;
         else begin
            e.op7.cla = bitOf(w, 7);
            e.op7.cll = bitOf(w, 6);
            e.op7.cma = bitOf(w, 5);
            e.op7.cml = bitOf(w, 4);
            e.op7.iac = bitOf(w, 0);
            if (bitOf(w, 3)) begin
               if (bitOf(w, 1)) e.op7.rtr = 1'b1; else e.op7.rar = 1'b1;
            end
            if (bitOf(w, 2)) begin
               if (bitOf(w, 1)) e.op7.rtl = 1'b1; else e.op7.ral = 1'b1;
            end
         end
      end else if (bitOf(w, 0)) begin
         unsup = 1;
      end else begin
         e.op7.cla = bitOf(w, 7);
         e.op7.osr = bitOf(w, 2);
         e.op7.hlt = bitOf(w, 1);
         skipSel   = (w / 16) % 8;
         if (!bitOf(w, 3)) begin
            e.op7.sma = bitOf(w, 6);
            e.op7.sza = bitOf(w, 5);
            e.op7.snl = bitOf(w, 4);
         end else begin
            e.op7.spa = bitOf(w, 6);
            e.op7.sna = bitOf(w, 5);
            e.op7.szl = bitOf(w, 4);
            e.op7.skp = (skipSel == 0);
         end
      end
      if (unsup) begin
`ifdef IFD_ILLEGAL_HALT_EN
         e.op7.hlt = 1'b1;
`else
         e.mem.nop = 1'b1;
`endif
      end else if (e.mem == '0 && e.op7 == '0) begin
         e.mem.nop = 1'b1;
      end
      return e;
   endfunction

   // Memory responder: a request seen in FETCH returns data during the next
   // cycle; at other times the read bus carries junk.
   always @(negedge clk) begin
      if (reset) begin
         pending     = 1'b0;
         ifu_rd_data = 12'($urandom);
      end else begin
         if (pending) ifu_rd_data = mem[pendAddr];
         else         ifu_rd_data = 12'($urandom);
         pending  = ifu_rd_req;
         pendAddr = ifu_rd_addr;
      end
   end

   // Monitor: pops the scoreboard on each newly issued instruction, checks
   // the held value while issued and watches for back-to-back read requests.
   always @(negedge clk) begin
      exp_t cur;
      if (reset) begin
         prevValid = 1'b0;
         prevReq   = 1'b0;
      end else begin
         if (ifu_rd_req) checkOutput("reqNotBackToBack", 64'(prevReq), 64'd0);
         prevReq = ifu_rd_req;
         cur = {pdp_mem_opcode, pdp_op7_opcode, base_addr};
         if (cur.mem != '0 || cur.op7 != '0) begin
            if (!prevValid) begin
               if (sbQ.size() == 0) checkOutput("unexpectedIssue", 64'(cur), 64'd0);
               else begin
                  held = sbQ.pop_front();
                  checkOutput("decode", 64'(cur), 64'(held));
               end
            end else begin
               checkOutput("holdStable", 64'(cur), 64'(held));
            end
            prevValid = 1'b1;
         end else begin
            prevValid = 1'b0;
         end
      end
   end

   // One full instruction: fetch from pc, wait for issue, hold it for a few
   // cycles with stall low, then retire it with stall high.
   task automatic applyStimulus(input logic [11:0] pc, input logic [11:0] word,
                                input int hold, input int stallCyc);
      int n;
      mem[pc] = word;
      sbQ.push_back(refModel(int'(word), int'(pc)));
      PC_value = pc;
      stall    = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!ifu_rd_req && n < 8);
      checkOutput("fetchLatency", 64'(n), 64'd1);
      checkOutput("fetchAddr", 64'(ifu_rd_addr), 64'(pc));
      PC_value = 12'($urandom);
      n = 0;
      do begin @(negedge clk); n++; end
         while (pdp_mem_opcode == '0 && pdp_op7_opcode == '0 && n < 8);
      checkOutput("issueLatency", 64'(n), 64'd2);
      repeat (hold) begin
         @(negedge clk);
         checkOutput("noFetchInIssue", 64'(ifu_rd_req), 64'd0);
      end
      stall = 1'b1;
      repeat (stallCyc) begin
         @(negedge clk);
         checkOutput("retireZero", 64'({pdp_mem_opcode, pdp_op7_opcode, base_addr}), 64'd0);
      end
   endtask

   // Assert reset while the word is being loaded; everything must clear at once.
   task automatic resetDuringLoad(input logic [11:0] pc, input logic [11:0] word);
      int n;
      mem[pc] = word;
      sbQ.push_back(refModel(int'(word), int'(pc)));
      PC_value = pc;
      stall    = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!ifu_rd_req && n < 8);
      checkOutput("fetchBeforeReset", 64'(ifu_rd_addr), 64'(pc));
      @(posedge clk);
      #1 reset = 1'b1;
      sbQ.delete();
      #1 checkOutput("asyncResetClear",
                     64'({ifu_rd_req, ifu_rd_addr, pdp_mem_opcode, pdp_op7_opcode, base_addr}), 64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   typedef struct {
      logic [11:0] pc;
      logic [11:0] word;
   } dir_t;

   initial begin
      dir_t dirs[$];
      logic [11:0] w;
      int          cat;
      checksTotal  = 0;
      checksPassed = 0;
      reset        = 1'b1;
      stall        = 1'b1;
      PC_value     = '0;
      ifu_rd_data  = '0;
      for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);

      repeat (2) @(negedge clk);
      checkOutput("resetState",
                  64'({ifu_rd_req, ifu_rd_addr, pdp_mem_opcode, pdp_op7_opcode, base_addr}), 64'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("idleWhileStalled", 64'(ifu_rd_req), 64'd0);

      // Handshake case: long hold in ISSUE, three-cycle retire.
      applyStimulus(12'o0200, 12'o1377, 10, 3);

      dirs.push_back('{12'o4000, 12'o5010});
      dirs.push_back('{12'o4000, 12'o5410});
      dirs.push_back('{12'o3456, 12'o7300});
      dirs.push_back('{12'o0017, 12'o7450});
      dirs.push_back('{12'o1000, 12'o7402});
      dirs.push_back('{12'o2222, 12'o6001});
      dirs.push_back('{12'o0400, 12'o7000});
      dirs.push_back('{12'o0401, 12'o7014});
      dirs.push_back('{12'o0402, 12'o7401});
      dirs.push_back('{12'o0403, 12'o7410});
      dirs.push_back('{12'o7777, 12'o3777});
      foreach (dirs[i]) applyStimulus(dirs[i].pc, dirs[i].word, 0, 1);

      resetDuringLoad(12'o0300, 12'o1377);
      applyStimulus(12'o5200, 12'o2300, 1, 1);

      for (int i = 0; i < 60; i++) begin
         cat = $urandom_range(0, 9);
         if (cat <= 4)      w = {3'($urandom_range(0, 5)), 9'($urandom)};
         else if (cat <= 6) w = {3'o7, 1'b0, 8'($urandom)};
         else if (cat <= 8) w = {3'o7, 1'b1, 7'($urandom), 1'b0};
         else               w = 12'($urandom);
         applyStimulus(12'($urandom), w, $urandom_range(0, 3), $urandom_range(1, 3));
      end

      checkOutput("scoreboardDrained", 64'(sbQ.size()), 64'd0);
      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
